// File: rtl/sysid_pkg.sv
// Shared types and constants for the system-ID probe master.
// Holds the probe FSM encoding, slave word addresses and default expected words.
package sysid_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ_ID = 3'd1,
    ST_LAT_ID = 3'd2,
    ST_REQ_TS = 3'd3,
    ST_LAT_TS = 3'd4,
    ST_FIN    = 3'd5
  } state_t;

  localparam logic        SYSID_ADDR_ID    = 1'b0;
  localparam logic        SYSID_ADDR_TS    = 1'b1;
  localparam logic [31:0] SYSID_DEFAULT_ID = 32'h0000_0000;
  localparam logic [31:0] SYSID_DEFAULT_TS = 32'h61E7_B90C;

endpackage

// File: rtl/avm_read_phase.sv
// One Avalon-MM read phase: request held through waitrequest, fixed read latency, per-phase timeout.
// Data capture is flagged READ_LATENCY cycles after accept; a capture beats a timeout in the same cycle.
module avm_read_phase #(
  parameter int unsigned READ_LATENCY   = 0,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_req,
  input  logic i_lat,
  input  logic i_avm_waitreq,
  output logic o_avm_read,
  output logic o_accept,
  output logic o_capture,
  output logic o_timeout
);

  localparam logic [2:0]  LAT_LOAD = READ_LATENCY[2:0];
  localparam logic [15:0] TMO_MAX  = TIMEOUT_CYCLES[15:0];

  logic [15:0] r_tmo_cnt;
  logic [2:0]  r_lat_cnt;
  logic        w_active;
  logic        w_tmo_hit;
  logic        w_accept;
  logic        w_capture;
  logic        w_timeout;

  assign w_active   = i_req | i_lat;
  assign w_tmo_hit  = w_active && (r_tmo_cnt == TMO_MAX);
  assign o_avm_read = i_req & ~w_tmo_hit;
  assign w_accept   = o_avm_read & ~i_avm_waitreq;
  // Zero latency: data is valid alongside the accept itself.
  assign w_capture  = (LAT_LOAD == 3'd0) ? w_accept : (i_lat && (r_lat_cnt == 3'd1));
  assign w_timeout  = w_tmo_hit & ~w_capture;

  assign o_accept   = w_accept;
  assign o_capture  = w_capture;
  assign o_timeout  = w_timeout;

  always_ff @(posedge i_clock) begin
    if (i_reset || !w_active || w_capture || w_timeout) begin
      r_tmo_cnt <= '0;
    end else begin
      r_tmo_cnt <= r_tmo_cnt + 16'd1;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_lat_cnt <= '0;
    end else if (w_accept) begin
      r_lat_cnt <= LAT_LOAD;
    end else if (i_lat && (r_lat_cnt != 3'd0)) begin
      r_lat_cnt <= r_lat_cnt - 3'd1;
    end
  end

endmodule

// File: rtl/sysid_check_master.sv
// Probes a sysid slave (word 0 = ID, word 1 = timestamp) and reports match/timeout flags.
// Start-to-done is 2*(1+READ_LATENCY)+1 cycles without stalls; start is ignored while busy.
module sysid_check_master
  import sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = SYSID_DEFAULT_ID,
  parameter logic [31:0] EXPECTED_TS    = SYSID_DEFAULT_TS,
  parameter int unsigned READ_LATENCY   = 0,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_start,
  output logic        o_avm_address,
  output logic        o_avm_read,
  input  logic        i_avm_waitreq,
  input  logic [31:0] i_avm_readdata,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_id_match,
  output logic        o_ts_match,
  output logic        o_timeout,
  output logic [31:0] o_id_value,
  output logic [31:0] o_ts_value
);

  state_t      r_state;
  state_t      w_next;
  logic        r_auto_pend;
  logic        r_id_match;
  logic        r_ts_match;
  logic        r_timeout;
  logic [31:0] r_id_value;
  logic [31:0] r_ts_value;
  logic        w_req;
  logic        w_lat;
  logic        w_is_ts;
  logic        w_launch;
  logic        w_accept;
  logic        w_capture;
  logic        w_timeout;

  assign w_req    = (r_state == ST_REQ_ID) || (r_state == ST_REQ_TS);
  assign w_lat    = (r_state == ST_LAT_ID) || (r_state == ST_LAT_TS);
  assign w_is_ts  = (r_state == ST_REQ_TS) || (r_state == ST_LAT_TS);
  assign w_launch = (r_state == ST_IDLE) && (i_start || r_auto_pend);

  avm_read_phase #(
    .READ_LATENCY   (READ_LATENCY),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_phase (
    .i_clock       (i_clock),
    .i_reset       (i_reset),
    .i_req         (w_req),
    .i_lat         (w_lat),
    .i_avm_waitreq (i_avm_waitreq),
    .o_avm_read    (o_avm_read),
    .o_accept      (w_accept),
    .o_capture     (w_capture),
    .o_timeout     (w_timeout)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_launch) w_next = ST_REQ_ID;
      ST_REQ_ID: begin
        if (w_timeout)      w_next = ST_FIN;
        else if (w_capture) w_next = ST_REQ_TS;
        else if (w_accept)  w_next = ST_LAT_ID;
      end
      ST_LAT_ID: begin
        if (w_timeout)      w_next = ST_FIN;
        else if (w_capture) w_next = ST_REQ_TS;
      end
      ST_REQ_TS: begin
        if (w_timeout || w_capture) w_next = ST_FIN;
        else if (w_accept)          w_next = ST_LAT_TS;
      end
      ST_LAT_TS: if (w_timeout || w_capture) w_next = ST_FIN;
      ST_FIN:    w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_busy        = (r_state != ST_IDLE);
    o_done        = (r_state == ST_FIN);
    o_avm_address = w_is_ts ? SYSID_ADDR_TS : SYSID_ADDR_ID;
  end

  // Match flags are registered at capture so they are settled by the done cycle.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_auto_pend <= AUTO_START;
      r_id_match  <= 1'b0;
      r_ts_match  <= 1'b0;
      r_timeout   <= 1'b0;
      r_id_value  <= '0;
      r_ts_value  <= '0;
    end else begin
      if (w_launch) begin
        r_auto_pend <= 1'b0;
        r_id_match  <= 1'b0;
        r_ts_match  <= 1'b0;
        r_timeout   <= 1'b0;
        r_id_value  <= '0;
        r_ts_value  <= '0;
      end
      if (w_capture && !w_is_ts) begin
        r_id_value <= i_avm_readdata;
        r_id_match <= (i_avm_readdata == EXPECTED_ID);
      end
      if (w_capture && w_is_ts) begin
        r_ts_value <= i_avm_readdata;
        r_ts_match <= (i_avm_readdata == EXPECTED_TS);
      end
      if (w_timeout) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign o_id_match = r_id_match;
  assign o_ts_match = r_ts_match;
  assign o_timeout  = r_timeout;
  assign o_id_value = r_id_value;
  assign o_ts_value = r_ts_value;

endmodule
